lut_frac: RTL and testbench



---
 rtl/clb_pkg.sv | 16 +
 rtl/lut_frac_if.sv | 33 +++
 rtl/cfg_shift_chain.sv | 62 ++++++
 rtl/lut_frac.sv | 81 ++++++++
 tb/tb_lut_frac.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/clb_pkg.sv
// Shared CLB configuration constants and types.
// Used by the LUT and by other configuration elements in the CLB.
package clb_pkg;

   // Default configuration stream word width.
   parameter int unsigned CONFIG_WIDTH_DEF = 8;

   // Position of the fracture-mode flag inside the mode word.
   parameter int unsigned FRAC_MODE_BIT = 0;

   typedef enum logic {
      ModeSingle = 1'b0,  // one INPUTS-input LUT
      ModeFrac   = 1'b1   // two (INPUTS-1)-input LUTs sharing the low address bits
   } lut_mode_e;

endpackage

// File: rtl/lut_frac_if.sv
// Bus bundle of the fracturable LUT.
//   config_en/config_in : config stream into the LUT
//   config_out          : oldest chain word, feeds the next LUT in the chain
//   config_done         : all config words received since reset
//   frac_mode           : stored mode flag
//   addr                : LUT address
//   out_a/out_b         : primary and second fractured outputs
// master = driver of the LUT (fabric/bench), slave = the LUT itself.
interface lut_frac_if #(
   parameter int unsigned INPUTS       = 4,
   parameter int unsigned CONFIG_WIDTH = clb_pkg::CONFIG_WIDTH_DEF
) ();

   logic                    config_en;
   logic [CONFIG_WIDTH-1:0] config_in;
   logic [CONFIG_WIDTH-1:0] config_out;
   logic                    config_done;
   logic                    frac_mode;
   logic [INPUTS-1:0]       addr;
   logic                    out_a;
   logic                    out_b;

   modport master (
      output config_en, config_in, addr,
      input  config_out, config_done, frac_mode, out_a, out_b
   );

   modport slave (
      input  config_en, config_in, addr,
      output config_out, config_done, frac_mode, out_a, out_b
   );

endinterface

// File: rtl/cfg_shift_chain.sv
// Generic configuration shift chain: NumWords x Width register chain with a
// saturating accepted-word counter and a registered done flag.
//   clk_i   : clock, all updates on rising edge
//   rst_i   : synchronous active-high reset, wins over en_i
//   en_i    : shift enable, one word accepted per cycle while high
//   data_i  : word shifted into position 0
//   data_o  : word at the far end of the chain (daisy-chain output)
//   words_o : all chain words, word k at bits [k*Width +: Width]
//   done_o  : NumWords words accepted since reset (sticky until reset)
module cfg_shift_chain #(
   parameter int unsigned NumWords = 3,
   parameter int unsigned Width    = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      en_i,
   input  logic [Width-1:0]          data_i,
   output logic [Width-1:0]          data_o,
   output logic [NumWords*Width-1:0] words_o,
   output logic                      done_o
);

   localparam int unsigned CntW = $clog2(NumWords + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(NumWords);

   logic [NumWords-1:0][Width-1:0] words_q, words_d;
   logic [CntW-1:0]                cnt_q, cnt_d;
   logic                           done_q, done_d;

   always_comb begin
      words_d = words_q;
      cnt_d   = cnt_q;
      if (en_i) begin
         words_d[0] = data_i;
         for (int k = 1; k < int'(NumWords); k++) begin
            words_d[k] = words_q[k-1];
         end
         // Counter saturates so pass-through traffic never clears done.
         if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
      done_d = (cnt_d == CntMax);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         words_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         words_q <= words_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign data_o  = words_q[NumWords-1];
   assign words_o = words_q;
   assign done_o  = done_q;

endmodule

// File: rtl/lut_frac.sv
// Fracturable LUT. Truth table and mode word are loaded through a daisy-chainable
// config shift chain (mode word first, truth table low word last).
//   config_clk : sole clock
//   config_rst : synchronous active-high reset
//   bus        : lut_frac_if slave (config stream, chain output, done, mode, lookup)
// Outputs stay 0 until the whole configuration has been received.
module lut_frac
   import clb_pkg::*;
#(
   parameter int unsigned INPUTS       = 4,
   parameter int unsigned CONFIG_WIDTH = CONFIG_WIDTH_DEF
) (
   input logic       config_clk,
   input logic       config_rst,
   lut_frac_if.slave bus
);

   localparam int unsigned MEM_SIZE  = 2 ** INPUTS;
   localparam int unsigned MEM_WORDS = MEM_SIZE / CONFIG_WIDTH;
   localparam int unsigned NUM_WORDS = MEM_WORDS + 1;

   if (INPUTS < 2) begin : g_bad_inputs
      $error("lut_frac: INPUTS must be >= 2");
   end
   if ((MEM_SIZE % CONFIG_WIDTH) != 0) begin : g_bad_width
      $error("lut_frac: 2**INPUTS must be a multiple of CONFIG_WIDTH");
   end

   logic [NUM_WORDS*CONFIG_WIDTH-1:0] chain_words;
   logic                              cfg_done;
   logic [MEM_SIZE-1:0]               mem;
   logic [CONFIG_WIDTH-1:0]           mode_word;
   lut_mode_e                         mode;
   logic [INPUTS-2:0]                 half_addr;
   logic                              out_a, out_b;
   logic                              unused_mode_rsvd;

   cfg_shift_chain #(
      .NumWords (NUM_WORDS),
      .Width    (CONFIG_WIDTH)
   ) u_chain (
      .clk_i   (config_clk),
      .rst_i   (config_rst),
      .en_i    (bus.config_en),
      .data_i  (bus.config_in),
      .data_o  (bus.config_out),
      .words_o (chain_words),
      .done_o  (cfg_done)
   );

   // Words 0..MEM_WORDS-1 form the truth table (word 0 lowest); the top word is the mode word.
   assign mem       = chain_words[MEM_SIZE-1:0];
   assign mode_word = chain_words[MEM_WORDS*CONFIG_WIDTH +: CONFIG_WIDTH];
   assign mode      = lut_mode_e'(mode_word[FRAC_MODE_BIT]);
   // Reserved mode bits are carried by the chain but have no function here.
   assign unused_mode_rsvd = ^mode_word;

   assign half_addr = bus.addr[INPUTS-2:0];

   always_comb begin
      out_a = 1'b0;
      out_b = 1'b0;
      if (cfg_done) begin
         unique case (mode)
            ModeSingle: out_a = mem[bus.addr];
            ModeFrac: begin
               // Lower half of the table drives out_a, upper half out_b; addr MSB ignored.
               out_a = mem[{1'b0, half_addr}];
               out_b = mem[{1'b1, half_addr}];
            end
            default: ;
         endcase
      end
   end

   assign bus.out_a       = out_a;
   assign bus.out_b       = out_b;
   assign bus.config_done = cfg_done;
   assign bus.frac_mode   = mode_word[FRAC_MODE_BIT];

endmodule

// File: tb/tb_lut_frac.sv
// Self-checking bench for lut_frac (INPUTS=4, CONFIG_WIDTH=8).
// Stimulus pushes expected outputs into a queue; a monitor on the falling edge
// pops and compares against the DUT.
module tb_lut_frac;

   localparam int INPUTS = 4;
   localparam int CW     = 8;
   localparam int NW     = (2 ** INPUTS) / CW + 1;

   typedef struct packed {
      logic [CW-1:0] cfg_out;
      logic          done;
      logic          frac;
      logic          a;
      logic          b;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lut_frac_if #(.INPUTS(INPUTS), .CONFIG_WIDTH(CW)) bus ();

   lut_frac #(
      .INPUTS       (INPUTS),
      .CONFIG_WIDTH (CW)
   ) dut (
      .config_clk (clk),
      .config_rst (rst),
      .bus        (bus)
   );

   // Reference model: list of received words, newest at index 0, and a word count.
   logic [CW-1:0] mw [NW];
   int            mcnt;
   logic          cur_rst, cur_en;
   logic [CW-1:0] cur_din;

   exp_t  exp_q [$];
   string tag_q [$];
   int    n_chk  = 0;
   int    n_pass = 0;

   function automatic exp_t model_out(input logic [INPUTS-1:0] a);
      exp_t        e;
      logic [15:0] table_bits;
      int          h;
      table_bits = {mw[1], mw[0]};
      e.cfg_out  = mw[NW-1];
      e.frac     = mw[NW-1][0];
      e.done     = (mcnt >= NW);
      e.a        = 1'b0;
      e.b        = 1'b0;
      if (e.done) begin
         if (!e.frac) begin
            e.a = table_bits[a];
         end else begin
            h   = int'(a) % 8;
            e.a = table_bits[h];
            e.b = table_bits[8 + h];
         end
      end
      return e;
   endfunction

   // One clock: account for the edge just taken, then present new inputs and
   // queue the outputs expected until the next edge.
   task automatic cyc(input logic r, input logic e, input logic [CW-1:0] d,
                      input logic [INPUTS-1:0] a, input string tag);
      @(posedge clk);
      #1;
      if (cur_rst) begin
         for (int k = 0; k < NW; k++) mw[k] = '0;
         mcnt = 0;
      end else if (cur_en) begin
         for (int k = NW - 1; k > 0; k--) mw[k] = mw[k-1];
         mw[0] = cur_din;
         if (mcnt < NW) mcnt++;
      end
      cur_rst = r;
      cur_en  = e;
      cur_din = d;
      rst           = r;
      bus.config_en = e;
      bus.config_in = d;
      bus.addr      = a;
      exp_q.push_back(model_out(a));
      tag_q.push_back(tag);
   endtask

   task automatic load3(input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                        input logic [CW-1:0] w2, input string tag);
      cyc(1'b0, 1'b1, w0, '0, tag);
      cyc(1'b0, 1'b1, w1, '0, tag);
      cyc(1'b0, 1'b1, w2, '0, tag);
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, '0, 4'(i), tag);
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t  e;
      exp_t  act;
      string t;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         t   = tag_q.pop_front();
         act = {bus.config_out, bus.config_done, bus.frac_mode, bus.out_a, bus.out_b};
         n_chk++;
         if (act === e) begin
            n_pass++;
         end else begin
            $display("FAIL %s addr=%h: got out=%h done=%b frac=%b a=%b b=%b, want out=%h done=%b frac=%b a=%b b=%b",
                     t, bus.addr, act.cfg_out, act.done, act.frac, act.a, act.b,
                     e.cfg_out, e.done, e.frac, e.a, e.b);
         end
      end
   end

   initial begin
      rst           = 1'b1;
      bus.config_en = 1'b0;
      bus.config_in = '0;
      bus.addr      = '0;
      cur_rst       = 1'b1;
      cur_en        = 1'b0;
      cur_din       = '0;
      mcnt          = 0;
      for (int k = 0; k < NW; k++) mw[k] = '0;

      cyc(1'b1, 1'b0, '0, '0, "reset");
      cyc(1'b0, 1'b0, '0, '0, "after_reset");
      sweep("noconfig");

      // Mode 0, table 0xF00F
      load3(8'h00, 8'hF0, 8'h0F, "load_m0");
      cyc(1'b0, 1'b0, '0, 4'd0, "m0_a0");
      cyc(1'b0, 1'b0, '0, 4'd4, "m0_a4");
      cyc(1'b0, 1'b0, '0, 4'd12, "m0_a12");
      sweep("m0_sweep");

      // Mode 1, same table
      cyc(1'b1, 1'b0, '0, '0, "rst2");
      load3(8'h01, 8'hF0, 8'h0F, "load_m1");
      cyc(1'b0, 1'b0, '0, 4'd3, "m1_a3");
      cyc(1'b0, 1'b0, '0, 4'd4, "m1_a4");
      cyc(1'b0, 1'b0, '0, 4'd12, "m1_a12");
      sweep("m1_sweep");

      // Pass-through with gaps
      cyc(1'b1, 1'b0, '0, '0, "rst3");
      load3(8'h00, 8'hF0, 8'h0F, "load_pt");
      cyc(1'b0, 1'b1, 8'hAB, '0, "pt_push1");
      cyc(1'b0, 1'b0, '0, '0, "pt_gap1");
      cyc(1'b0, 1'b1, 8'hCD, '0, "pt_push2");
      cyc(1'b0, 1'b0, '0, '0, "pt_gap2");
      cyc(1'b0, 1'b1, 8'hEF, '0, "pt_push3");
      sweep("pt_sweep");

      // Reset mid-load, reset wins over config_en
      cyc(1'b1, 1'b0, '0, '0, "rst4");
      cyc(1'b0, 1'b1, 8'h5A, '0, "part1");
      cyc(1'b0, 1'b1, 8'hC3, '0, "part2");
      cyc(1'b1, 1'b1, 8'h77, '0, "rst_with_en");
      cyc(1'b0, 1'b0, '0, '0, "after_midrst");
      load3(8'h01, 8'h96, 8'h3C, "reload");
      sweep("reload_sweep");

      // Saturation: 10 extra pushes beyond a full load
      for (int i = 0; i < 13; i++) cyc(1'b0, 1'b1, 8'($urandom), 4'($urandom), "sat");
      sweep("sat_sweep");

      // Random streams
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
             8'($urandom), 4'($urandom), "random");
      end
      cyc(1'b0, 1'b0, '0, '0, "final");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_chk++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
